morse_symbol_classifier: RTL and testbench

Downstream consumer of the units counter in the Morse receive path. Watches the sampled key level, fires the counter's `start` on every key edge, and classifies each completed mark or space from the BCD `units_cnt`. Mark intervals become DOT or DASH; space intervals become CHAR_END or WORD_END. Symbols are queued in a small FIFO for the decoder stage behind a valid/ready handshake.

---
 rtl/morse_symbol_classifier_pkg.sv | 22 ++
 rtl/morse_sym_fifo.sv | 48 ++++
 rtl/morse_symbol_classifier.sv | 114 +++++++++++
 tb/tb_morse_symbol_classifier.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/morse_symbol_classifier_pkg.sv
// Shared symbol/state encodings and default BCD thresholds for the Morse
// symbol classifier and its output queue.
package morse_symbol_classifier_pkg;

    typedef enum logic [1:0] {
        SYM_DOT      = 2'b00,
        SYM_DASH     = 2'b01,
        SYM_CHAR_END = 2'b10,
        SYM_WORD_END = 2'b11
    } sym_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MARK  = 2'b01,
        ST_SPACE = 2'b10
    } state_e;

    localparam logic [23:0] DEF_DASH_MIN = 24'h000002;
    localparam logic [23:0] DEF_CHAR_MIN = 24'h000002;
    localparam logic [23:0] DEF_WORD_MIN = 24'h000005;

endpackage

// File: rtl/morse_sym_fifo.sv
// 2-bit symbol FIFO with a register-backed head; a push into a full queue is
// accepted when a pop happens on the same clock.
module morse_sym_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [1:0] push_data_i,
    input  logic       pop_i,
    output logic [1:0] head_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [1:0]  mem_q [DEPTH];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic        do_pop;
    logic        do_push;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // When full, the write slot equals the slot being popped, so overwriting it is safe.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= push_data_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_symbol_classifier.sv
// Classifies key marks/spaces into DOT/DASH/CHAR_END/WORD_END from the BCD
// units count and queues them for the decoder.
module morse_symbol_classifier
    import morse_symbol_classifier_pkg::*;
#(
    parameter logic [23:0] DASH_MIN   = DEF_DASH_MIN,
    parameter logic [23:0] CHAR_MIN   = DEF_CHAR_MIN,
    parameter logic [23:0] WORD_MIN   = DEF_WORD_MIN,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        key,
    input  logic [23:0] units_cnt,
    output logic        start,
    output logic [1:0]  sym,
    output logic        sym_valid,
    input  logic        sym_ready,
    output logic        overflow,
    input  logic        clr_ovf
);
    state_e state_q, state_d;
    logic   key_q;
    logic   char_sent_q, char_sent_d;
    logic   overflow_q;
    logic   edge_det;
    logic   push;
    sym_e   push_sym;
    logic   pop;
    logic   fifo_full;
    logic   fifo_empty;

    assign edge_det = ce && (key != key_q);
    assign start    = edge_det;

    always_comb begin
        state_d     = state_q;
        char_sent_d = char_sent_q;
        push        = 1'b0;
        push_sym    = SYM_DOT;
        if (ce) begin
            case (state_q)
                ST_IDLE: begin
                    if (edge_det) state_d = ST_MARK;
                end
                ST_MARK: begin
                    if (edge_det) begin
                        push        = 1'b1;
                        push_sym    = (units_cnt < DASH_MIN) ? SYM_DOT : SYM_DASH;
                        state_d     = ST_SPACE;
                        char_sent_d = 1'b0;
                    end
                end
                ST_SPACE: begin
                    // BCD is monotonic, so plain unsigned compares order the counts correctly.
                    if (edge_det) begin
                        state_d = ST_MARK;
                    end else if (units_cnt >= WORD_MIN) begin
                        push     = 1'b1;
                        push_sym = SYM_WORD_END;
                        state_d  = ST_IDLE;
                    end else if ((units_cnt >= CHAR_MIN) && !char_sent_q) begin
                        push        = 1'b1;
                        push_sym    = SYM_CHAR_END;
                        char_sent_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            key_q       <= 1'b0;
            char_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            char_sent_q <= char_sent_d;
            if (ce) key_q <= key;
        end
    end

    assign pop = sym_valid && sym_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end else if (clr_ovf) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow  = overflow_q;
    assign sym_valid = !fifo_empty;

    morse_sym_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_data_i(push_sym),
        .pop_i      (pop),
        .head_o     (sym),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule

// File: tb/tb_morse_symbol_classifier.sv
// Scoreboard bench: a behavioural model of the symbol rules queues expected
// symbols; a negedge monitor compares whatever the DUT hands off.
module tb_morse_symbol_classifier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        key;
    logic [23:0] units_cnt;
    logic        start;
    logic [1:0]  sym;
    logic        sym_valid;
    logic        sym_ready;
    logic        overflow;
    logic        clr_ovf;

    int checks = 0;
    int errors = 0;

    logic [1:0] sb_q[$];
    int occ = 0, occ_n = 0;
    bit ovf_m = 0, ovf_n = 0;
    bit kprev = 0, in_space = 0, cs = 0;
    bit acc = 0;
    logic [1:0] acc_sym = 2'b00;

    localparam int DEPTH = 4;

    morse_symbol_classifier #(
        .DASH_MIN  (24'h000002),
        .CHAR_MIN  (24'h000002),
        .WORD_MIN  (24'h000005),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .key      (key),
        .units_cnt(units_cnt),
        .start    (start),
        .sym      (sym),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < 6; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares handed-off symbols and the queue-level outputs.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("sym_valid", int'(sym_valid), int'(occ > 0));
            chk("overflow", int'(overflow), int'(ovf_m));
            if (sym_valid && sym_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sym_unexpected: got %0d expected none", sym);
                end else begin
                    chk("sym", int'(sym), int'(sb_q.pop_front()));
                end
            end
        end
    end

    task automatic model_reset();
        sb_q.delete();
        occ = 0; occ_n = 0; ovf_m = 0; ovf_n = 0;
        kprev = 0; in_space = 0; cs = 0; acc = 0;
    endtask

    // Drive one clock of inputs; model the rules; commit at the edge.
    task automatic step(input bit c, input bit k, input int u, input bit r, input bit cl);
        bit exp_start, has, pop;
        logic [1:0] s;
        ce = c; key = k; units_cnt = to_bcd(u); sym_ready = r; clr_ovf = cl;
        @(negedge clk);
        exp_start = c && (k != kprev);
        chk("start", int'(start), int'(exp_start));
        has = 0; s = 2'b00;
        pop = (occ > 0) && r;
        if (c) begin
            if (k != kprev) begin
                if (kprev) begin
                    has = 1; s = (u < 2) ? 2'b00 : 2'b01;
                    in_space = 1; cs = 0;
                end else begin
                    in_space = 0;
                end
                kprev = k;
            end else if (in_space) begin
                if (u >= 5) begin
                    has = 1; s = 2'b11; in_space = 0;
                end else if (u >= 2 && !cs) begin
                    has = 1; s = 2'b10; cs = 1;
                end
            end
        end
        acc     = has && ((occ < DEPTH) || pop);
        acc_sym = s;
        occ_n   = occ - int'(pop) + int'(acc);
        ovf_n   = (has && !acc) ? 1'b1 : (cl ? 1'b0 : ovf_m);
        @(posedge clk);
        occ   = occ_n;
        ovf_m = ovf_n;
        if (acc) sb_q.push_back(acc_sym);
        #1;
    endtask

    task automatic do_reset(input bit k);
        ce = 0; key = k; sym_ready = 0; clr_ovf = 0; units_cnt = '0;
        #2 rst_n = 0;
        model_reset();
        #3;
        chk("rst_sym_valid", int'(sym_valid), 0);
        chk("rst_sym", int'(sym), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_start", int'(start), 0);
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic mark(input int len, input bit r);
        step(1, 1, 0, r, 0);
        step(1, 0, len, r, 0);
    endtask

    initial begin
        rst_n = 0; ce = 0; key = 0; units_cnt = '0; sym_ready = 0; clr_ovf = 0;
        @(posedge clk); #1;
        do_reset(0);

        // DOT, with latency check right after the classifying edge
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("lat_valid", int'(sym_valid), 1);
        chk("lat_sym", int'(sym), 0);
        step(0, 0, 0, 1, 0);
        // DASH
        mark(3, 1);
        // Space: CHAR_END then WORD_END, following rise emits nothing
        step(1, 0, 1, 1, 0);
        step(1, 0, 2, 1, 0);
        step(1, 0, 3, 1, 0);
        step(1, 0, 5, 1, 0);
        step(1, 1, 7, 1, 0);
        step(1, 0, 1, 1, 0);
        // Jump across both thresholds: WORD_END only
        step(1, 0, 1, 1, 0);
        step(1, 0, 6, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("sb_empty_1", sb_q.size(), 0);

        // Overflow: five DOTs with consumer stalled
        for (int i = 0; i < 5; i++) mark(1, 0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_occ", occ, DEPTH);
        // Push with pop while full: accepted
        step(1, 0, 2, 1, 0);
        chk("full_pushpop_occ", occ, DEPTH);
        step(0, 0, 0, 0, 1);
        chk("ovf_clr", int'(overflow), 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);

        // Reset mid-mark, key held high through release
        step(1, 1, 0, 1, 0);
        step(1, 1, 2, 1, 0);
        do_reset(1);
        step(1, 1, 4, 1, 0);
        step(1, 1, 1, 1, 0);
        step(1, 0, 3, 1, 0);
        step(0, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit c, k, r, cl;
            c  = ($urandom % 2) == 0;
            k  = (($urandom % 6) == 0) ? ~key : key;
            r  = ((i / 300) % 2 == 1) ? (($urandom % 5) == 0) : (($urandom % 4) != 0);
            cl = ($urandom % 16) == 0;
            step(c, k, int'($urandom_range(0, 7)), r, cl);
        end

        for (int i = 0; i < 10; i++) step(0, key, 0, 1, 0);
        chk("drain_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
